gpio_bank: RTL and testbench

//  Parametrised memory-mapped GPIO bank for the SOC IO page; generalises the single 32-bit GPIO_register.

---
 rtl/gpio_bank_pkg.sv | 42 ++++
 rtl/gpio_bank_if.sv | 25 ++
 rtl/gpio_bank_sync.sv | 34 +++
 rtl/gpio_bank.sv | 145 ++++++++++++++
 tb/tb_gpio_bank.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_bank_pkg.sv
// gpio_bank register offsets, INFO magic and small helpers.
// Shared by the bank, its bus interface and firmware header generation.
package gpio_bank_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t GPIO_DATA_OUT = 4'd0;
  localparam reg_addr_t GPIO_DIR      = 4'd1;
  localparam reg_addr_t GPIO_DATA_IN  = 4'd2;
  localparam reg_addr_t GPIO_SET      = 4'd3;
  localparam reg_addr_t GPIO_CLR      = 4'd4;
  localparam reg_addr_t GPIO_TGL      = 4'd5;
  localparam reg_addr_t GPIO_IRQ_EN   = 4'd6;
  localparam reg_addr_t GPIO_IRQ_RISE = 4'd7;
  localparam reg_addr_t GPIO_IRQ_FALL = 4'd8;
  localparam reg_addr_t GPIO_IRQ_STAT = 4'd9;
  localparam reg_addr_t GPIO_INFO     = 4'd10;

  localparam logic [15:0] GPIO_INFO_MAGIC = 16'h6B10;

  function automatic logic [31:0] lane_mask(
    input logic [3:0] wm
  );
    return {{8{wm[3]}}, {8{wm[2]}},
            {8{wm[1]}}, {8{wm[0]}}};
  endfunction

  function automatic logic [31:0] pin_mask(
    input int n
  );
    return 32'((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [31:0] lm
  );
    return (old & ~lm) | (wd & lm);
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Processor mem_* bus slice seen by gpio_bank after
// SOC address decode.
interface gpio_bank_if;
  import gpio_bank_pkg::*;

  logic        sel;
  reg_addr_t   reg_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output sel, reg_addr, mem_rstrb,
    output mem_wmask, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  sel, reg_addr, mem_rstrb,
    input  mem_wmask, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/gpio_bank_sync.sv
// gpio_sync: per-bit flop chain bringing asynchronous
// pads into the clk domain; every stage resets to 0.
module gpio_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] chain_d [STAGES];

  // shift pads one stage per clock
  always_comb begin
    chain_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // chain registers, cleared on reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (!resetn) chain_q[i] <= '0;
      else         chain_q[i] <= chain_d[i];
    end
  end

  assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: N-pin memory-mapped GPIO with atomic
// set/clr/toggle, synchronized inputs and edge irqs.
import gpio_bank_pkg::*;

module gpio_bank #(
  parameter int          NPINS       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             resetn,
  gpio_bank_if.slave       bus,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [31:0] PMASK = pin_mask(NPINS);
  localparam logic [31:0] ORST  = OUT_RESET & PMASK;

  logic [NPINS-1:0] sync;
  logic [NPINS-1:0] prev_q, prev_d;

  logic [31:0] data_out_q, data_out_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic [31:0] irq_rise_q, irq_rise_d;
  logic [31:0] irq_fall_q, irq_fall_d;
  logic [31:0] irq_stat_q, irq_stat_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wr_en, rd_en;
  logic [31:0] lm, wd, dm;
  logic [31:0] sync_w, prev_w, evt;
  logic [31:0] stat_clr, rd_mux;

  gpio_sync #(
    .W      (NPINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (gpio_in),
    .dout   (sync)
  );

  assign wr_en  = bus.sel & |bus.mem_wmask;
  assign rd_en  = bus.sel & bus.mem_rstrb;
  assign lm     = lane_mask(bus.mem_wmask) & PMASK;
  assign wd     = bus.mem_wdata;
  assign dm     = wd & lm;
  assign sync_w = 32'(sync);
  assign prev_w = 32'(prev_q);

  // edge events; stat latching ignores IRQ_EN
  assign evt = ((sync_w & ~prev_w) & irq_rise_q)
             | ((~sync_w & prev_w) & irq_fall_q);

  // register writes, W1C and sticky event capture
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_rise_d = irq_rise_q;
    irq_fall_d = irq_fall_q;
    stat_clr   = '0;
    prev_d     = sync;
    if (wr_en) begin
      case (bus.reg_addr)
        GPIO_DATA_OUT:
          data_out_d = merge(data_out_q, wd, lm);
        GPIO_DIR:
          dir_d = merge(dir_q, wd, lm);
        GPIO_SET:
          data_out_d = data_out_q | dm;
        GPIO_CLR:
          data_out_d = data_out_q & ~dm;
        GPIO_TGL:
          data_out_d = data_out_q ^ dm;
        GPIO_IRQ_EN:
          irq_en_d = merge(irq_en_q, wd, lm);
        GPIO_IRQ_RISE:
          irq_rise_d = merge(irq_rise_q, wd, lm);
        GPIO_IRQ_FALL:
          irq_fall_d = merge(irq_fall_q, wd, lm);
        GPIO_IRQ_STAT:
          stat_clr = dm;
        default: ;
      endcase
    end
    // a fresh event on a bit beats its clear
    irq_stat_d = ((irq_stat_q & ~stat_clr) | evt)
               & PMASK;
  end

  // read mux sampled from pre-write state
  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      GPIO_DATA_OUT: rd_mux = data_out_q;
      GPIO_DIR:      rd_mux = dir_q;
      GPIO_DATA_IN:  rd_mux = sync_w;
      GPIO_IRQ_EN:   rd_mux = irq_en_q;
      GPIO_IRQ_RISE: rd_mux = irq_rise_q;
      GPIO_IRQ_FALL: rd_mux = irq_fall_q;
      GPIO_IRQ_STAT: rd_mux = irq_stat_q;
      GPIO_INFO:
        rd_mux = {GPIO_INFO_MAGIC,
                  8'(SYNC_STAGES),
                  8'(NPINS)};
      default:       rd_mux = '0;
    endcase
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  // state registers; reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_out_q <= ORST;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_stat_q <= '0;
      rdata_q    <= '0;
      prev_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_stat_q <= irq_stat_d;
      rdata_q    <= rdata_d;
      prev_q     <= prev_d;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign gpio_out      = data_out_q[NPINS-1:0];
  assign gpio_oe       = dir_q[NPINS-1:0];
  assign irq           = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed and randomized checks of gpio_bank against
// a register-level reference model.
module tb_gpio_bank;

  localparam int NP = 8;
  localparam int SS = 2;
  localparam logic [31:0] PM   = 32'h0000_00FF;
  localparam logic [31:0] INFO = 32'h6B10_0208;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NP-1:0] gpio_in;
  logic [NP-1:0] gpio_out;
  logic [NP-1:0] gpio_oe;
  logic          irq;

  gpio_bank_if bus ();

  gpio_bank #(
    .NPINS       (NP),
    .SYNC_STAGES (SS),
    .OUT_RESET   (32'h0)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_out, m_dir, m_en;
  logic [31:0] m_rise, m_fall, m_stat;
  logic [31:0] m_pins;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_out  = '0;
    m_dir  = '0;
    m_en   = '0;
    m_rise = '0;
    m_fall = '0;
    m_stat = '0;
  endtask

  task automatic m_write(input logic [3:0] a,
                         input logic [31:0] d,
                         input logic [3:0] wm);
    logic [31:0] lm, v;
    lm = '0;
    for (int k = 0; k < 4; k++)
      if (wm[k]) lm[8*k +: 8] = 8'hFF;
    lm = lm & PM;
    v  = d & lm;
    case (a)
      4'd0: m_out  = (m_out  & ~lm) | v;
      4'd1: m_dir  = (m_dir  & ~lm) | v;
      4'd3: m_out  = m_out | v;
      4'd4: m_out  = m_out & ~v;
      4'd5: m_out  = m_out ^ v;
      4'd6: m_en   = (m_en   & ~lm) | v;
      4'd7: m_rise = (m_rise & ~lm) | v;
      4'd8: m_fall = (m_fall & ~lm) | v;
      4'd9: m_stat = m_stat & ~v;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_read(
    input logic [3:0] a
  );
    case (a)
      4'd0:    return m_out;
      4'd1:    return m_dir;
      4'd2:    return m_pins & PM;
      4'd6:    return m_en;
      4'd7:    return m_rise;
      4'd8:    return m_fall;
      4'd9:    return m_stat;
      4'd10:   return INFO;
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle_bus();
    bus.sel       = 1'b0;
    bus.reg_addr  = '0;
    bus.mem_rstrb = 1'b0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input logic [3:0] wm);
    @(negedge clk);
    bus.sel       = 1'b1;
    bus.reg_addr  = a;
    bus.mem_wmask = wm;
    bus.mem_wdata = d;
    @(negedge clk);
    idle_bus();
    m_write(a, d, wm);
  endtask

  task automatic rd(input logic [3:0] a,
                    input string tag);
    logic [31:0] exp;
    exp = m_read(a);
    @(negedge clk);
    bus.sel       = 1'b1;
    bus.reg_addr  = a;
    bus.mem_rstrb = 1'b1;
    @(negedge clk);
    idle_bus();
    chk(tag, bus.mem_rdata, exp);
  endtask

  // drive pads, let them settle, fold edges into model
  task automatic pins(input logic [31:0] p);
    logic [31:0] o;
    o = m_pins;
    @(negedge clk);
    gpio_in = p[NP-1:0];
    repeat (SS + 2) @(negedge clk);
    m_pins = p & PM;
    m_stat = m_stat
           | (m_pins & ~o & m_rise)
           | (~m_pins & o & m_fall & PM);
  endtask

  task automatic chk_pins(input string tag);
    chk({tag, "_out"}, 32'(gpio_out), m_out);
    chk({tag, "_oe"},  32'(gpio_oe),  m_dir);
    chk({tag, "_irq"}, 32'(irq),
        32'(|(m_stat & m_en)));
  endtask

  initial begin
    resetn  = 1'b0;
    gpio_in = '0;
    m_pins  = '0;
    idle_bus();
    m_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk_pins("rst");
    rd(4'd0,  "rst_out");
    rd(4'd1,  "rst_dir");
    rd(4'd6,  "rst_en");
    rd(4'd9,  "rst_stat");
    rd(4'd10, "info");

    wr(4'd0, 32'hF0, 4'hF);
    wr(4'd3, 32'h05, 4'hF);
    wr(4'd4, 32'h80, 4'hF);
    wr(4'd5, 32'h11, 4'hF);
    chk("atomic_model", m_out, 32'h64);
    rd(4'd0, "atomic_rd");
    chk("atomic_pin", 32'(gpio_out), 32'h64);
    rd(4'd3, "set_rd0");

    @(negedge clk);
    bus.sel       = 1'b1;
    bus.reg_addr  = 4'd0;
    bus.mem_rstrb = 1'b1;
    bus.mem_wmask = 4'hF;
    bus.mem_wdata = 32'h3C;
    @(negedge clk);
    idle_bus();
    chk("rw_old", bus.mem_rdata, 32'h64);
    m_write(4'd0, 32'h3C, 4'hF);
    rd(4'd0, "rw_new");

    wr(4'd1, 32'hFFFF_FFFF, 4'b0001);
    rd(4'd1, "dir_lane0");
    chk("dir_exp", m_dir, 32'hFF);
    wr(4'd1, 32'h0, 4'b0000);
    rd(4'd1, "dir_nomask");

    wr(4'd7, 32'h01, 4'hF);
    wr(4'd6, 32'h01, 4'hF);
    @(negedge clk);
    gpio_in = 8'h01;
    @(negedge clk);
    chk("irq_t1", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_t2", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_t3", 32'(irq), 32'h1);
    m_pins = 32'h01;
    m_stat = 32'h01;
    rd(4'd9, "stat_rise");
    wr(4'd9, 32'h01, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd(4'd9, "w1c_stat");

    wr(4'd8, 32'h02, 4'hF);
    pins(32'h03);
    pins(32'h01);
    rd(4'd9, "fall_stat");
    pins(32'h03);
    @(negedge clk);
    gpio_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    bus.sel       = 1'b1;
    bus.reg_addr  = 4'd9;
    bus.mem_wmask = 4'hF;
    bus.mem_wdata = 32'h02;
    @(negedge clk);
    idle_bus();
    m_pins = 32'h01;
    m_stat = 32'h02;
    rd(4'd9, "w1c_race");

    pins(32'h00);
    wr(4'd7, 32'hFF, 4'hF);
    pins(32'hFF);
    rd(4'd9, "stat_ff");
    chk("stat_irq", 32'(irq), 32'h1);
    @(negedge clk);
    resetn        = 1'b0;
    bus.sel       = 1'b1;
    bus.reg_addr  = 4'd9;
    bus.mem_rstrb = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    idle_bus();
    m_reset();
    chk("mrst_rdata", bus.mem_rdata, 32'h0);
    chk_pins("mrst");
    rd(4'd9, "mrst_stat");
    rd(4'd7, "mrst_rise");
    rd(4'd2, "mrst_din");

    for (int i = 0; i < 80; i++) begin
      int op;
      logic [3:0] a;
      op = int'($urandom_range(0, 9));
      a  = 4'($urandom_range(0, 15));
      if (op < 6)
        wr(a, $urandom, 4'($urandom_range(0, 15)));
      else if (op < 8)
        rd(a, "rnd_rd");
      else
        pins($urandom);
      chk_pins("rnd");
    end
    for (int a = 0; a < 16; a++)
      rd(4'(a), "final_rd");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
